gpu_multi_raster_dispatch: RTL and testbench

// Command decoder/dispatcher for a GPU with NUM_RASTER parallel raster units, in the gpu_clk domain.

---
 rtl/gpu_multi_raster_dispatch.sv | 180 ++++++++++++++++++
 tb/tb_gpu_multi_raster_dispatch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gpu_multi_raster_dispatch.sv
// Command decoder/dispatcher for NUM_RASTER raster units and one tile writer.
// Broadcasts register writes, hands out START round-robin, orders tile writes, keeps perf counters.
module gpu_multi_raster_dispatch #(
    parameter int unsigned NUM_RASTER = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  gpu_clk_i,
    input  logic                  gpu_rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [7:0]            cmd_addr_i,
    input  logic [31:0]           cmd_data_i,
    output logic [NUM_RASTER-1:0] ras_reg_wren_o,
    output logic [3:0]            ras_reg_addr_o,
    output logic [31:0]           ras_reg_data_o,
    output logic [NUM_RASTER-1:0] ras_start_o,
    input  logic [NUM_RASTER-1:0] ras_busy_i,
    output logic [NUM_RASTER-1:0] ras_clear_o,
    output logic [NUM_RASTER-1:0] ras_buf_sel_o,
    output logic                  wr_start_o,
    output logic [2:0]            wr_unit_o,
    output logic                  wr_buf_sel_o,
    output logic [31:0]           wr_addr_o,
    output logic [15:0]           wr_stride_o,
    input  logic                  wr_reading_i,
    input  logic                  wr_flushed_i,
    input  logic [2:0]            cnt_sel_i,
    output logic [CNT_W-1:0]      cnt_data_o
);

    localparam int unsigned NumCnt   = 5;
    localparam logic [2:0]  LastUnit = 3'(NUM_RASTER - 1);
    localparam logic [3:0]  FullCnt  = 4'(NUM_RASTER);

    logic [2:0]            cur_q, cur_d, wr_q, wr_d;
    logic [3:0]            outst_q, outst_d;
    logic [NUM_RASTER-1:0] buf_sel_q, buf_sel_d, clear_q, clear_d, mask_q, mask_d;
    logic [31:0]           wr_addr_q, wr_addr_d;
    logic [15:0]           wr_stride_q, wr_stride_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q [NumCnt];
    logic [CNT_W-1:0]      cnt_d [NumCnt];
    logic [CNT_W-1:0]      cnt_data_q, cnt_data_d;

    logic [NUM_RASTER-1:0] cur_oh, wr_oh;
    logic                  is_ctrl, fence_ok, stall, accept;
    logic                  do_start, do_write, do_err, do_reset;
    logic [3:0]            op;

    always_comb begin
        cur_oh = '0;
        wr_oh  = '0;
        for (int i = 0; i < NUM_RASTER; i++) begin
            cur_oh[i] = (cur_q == 3'(i));
            wr_oh[i]  = (wr_q == 3'(i));
        end
    end

    assign is_ctrl  = (cmd_addr_i == 8'h00);
    assign op       = cmd_data_i[3:0];
    assign fence_ok = wr_flushed_i && !wr_reading_i && (ras_busy_i == '0);

    always_comb begin
        stall = 1'b0;
        if (cmd_valid_i && is_ctrl) begin
            case (op)
                4'd0:       stall = (|(ras_busy_i & cur_oh)) || (outst_q == FullCnt);
                4'd2:       stall = (outst_q != 4'd0) && ((|(ras_busy_i & wr_oh)) || wr_reading_i);
                4'd4, 4'd5: stall = !fence_ok;
                default:    stall = 1'b0;
            endcase
        end
    end

    // Gating with the reset makes every strobe drop as soon as reset asserts.
    assign accept   = gpu_rst_ni && cmd_valid_i && !stall;
    assign do_start = accept && is_ctrl && (op == 4'd0);
    assign do_write = accept && is_ctrl && (op == 4'd2) && (outst_q != 4'd0);
    assign do_err   = accept && is_ctrl && (op == 4'd2) && (outst_q == 4'd0);
    assign do_reset = accept && is_ctrl && (op == 4'd5);

    assign cmd_ready_o    = !stall;
    assign ras_reg_wren_o = (accept && cmd_addr_i[7:4] == 4'h1) ? mask_q : '0;
    assign ras_reg_addr_o = cmd_addr_i[3:0];
    assign ras_reg_data_o = cmd_data_i;
    assign ras_start_o    = do_start ? cur_oh : '0;
    assign ras_clear_o    = clear_q;
    assign ras_buf_sel_o  = buf_sel_q;
    assign wr_start_o     = do_write;
    assign wr_unit_o      = wr_q;
    // The writer drains the half the unit just filled, i.e. the pre-toggle selection.
    assign wr_buf_sel_o   = |(buf_sel_q & wr_oh);
    assign wr_addr_o      = wr_addr_q;
    assign wr_stride_o    = wr_stride_q;
    assign cnt_data_o     = cnt_data_q;

    always_comb begin
        cur_d       = cur_q;
        wr_d        = wr_q;
        outst_d     = outst_q;
        buf_sel_d   = buf_sel_q;
        clear_d     = clear_q;
        mask_d      = mask_q;
        wr_addr_d   = wr_addr_q;
        wr_stride_d = wr_stride_q;
        err_d       = err_q;
        if (accept && cmd_addr_i == 8'h01) wr_addr_d = cmd_data_i;
        if (accept && cmd_addr_i == 8'h02) wr_stride_d = cmd_data_i[15:0];
        if (accept && cmd_addr_i == 8'h03) mask_d = cmd_data_i[NUM_RASTER-1:0];
        if (do_start) begin
            clear_d = clear_q & ~cur_oh;
            cur_d   = (cur_q == LastUnit) ? 3'd0 : cur_q + 3'd1;
            outst_d = outst_q + 4'd1;
        end
        if (do_write) begin
            buf_sel_d = buf_sel_q ^ wr_oh;
            clear_d   = clear_q | wr_oh;
            wr_d      = (wr_q == LastUnit) ? 3'd0 : wr_q + 3'd1;
            outst_d   = outst_q - 4'd1;
        end
        if (do_err) err_d = 1'b1;
        if (do_reset) begin
            cur_d   = 3'd0;
            wr_d    = 3'd0;
            outst_d = 4'd0;
            err_d   = 1'b0;
            clear_d = '1;
        end
    end

    always_comb begin
        cnt_d[0] = cnt_q[0] + CNT_W'(1'b1);
        cnt_d[1] = cnt_q[1] + CNT_W'(ras_busy_i != '0);
        cnt_d[2] = cnt_q[2] + CNT_W'(wr_reading_i);
        cnt_d[3] = cnt_q[3] + CNT_W'(!cmd_valid_i);
        cnt_d[4] = cnt_q[4] + CNT_W'(cmd_valid_i && stall);
        if (do_reset) begin
            for (int i = 0; i < NumCnt; i++) cnt_d[i] = '0;
        end
        case (cnt_sel_i)
            3'd0:    cnt_data_d = cnt_q[0];
            3'd1:    cnt_data_d = cnt_q[1];
            3'd2:    cnt_data_d = cnt_q[2];
            3'd3:    cnt_data_d = cnt_q[3];
            3'd4:    cnt_data_d = cnt_q[4];
            3'd5:    cnt_data_d = CNT_W'(outst_q);
            3'd6:    cnt_data_d = CNT_W'({err_q, cur_q, wr_q});
            default: cnt_data_d = '0;
        endcase
    end

    always_ff @(posedge gpu_clk_i or negedge gpu_rst_ni) begin
        if (!gpu_rst_ni) begin
            cur_q       <= 3'd0;
            wr_q        <= 3'd0;
            outst_q     <= 4'd0;
            buf_sel_q   <= '0;
            clear_q     <= '1;
            mask_q      <= '1;
            wr_addr_q   <= '0;
            wr_stride_q <= '0;
            err_q       <= 1'b0;
            cnt_data_q  <= '0;
            for (int i = 0; i < NumCnt; i++) cnt_q[i] <= '0;
        end else begin
            cur_q       <= cur_d;
            wr_q        <= wr_d;
            outst_q     <= outst_d;
            buf_sel_q   <= buf_sel_d;
            clear_q     <= clear_d;
            mask_q      <= mask_d;
            wr_addr_q   <= wr_addr_d;
            wr_stride_q <= wr_stride_d;
            err_q       <= err_d;
            cnt_data_q  <= cnt_data_d;
            for (int i = 0; i < NumCnt; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: tb/tb_gpu_multi_raster_dispatch.sv
// Directed bench for gpu_multi_raster_dispatch with NUM_RASTER=2, CNT_W=32.
module tb_gpu_multi_raster_dispatch;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [1:0]  ras_reg_wren, ras_start, ras_busy, ras_clear, ras_buf_sel;
    logic [3:0]  ras_reg_addr;
    logic [31:0] ras_reg_data, wr_addr, cnt_data;
    logic        wr_start, wr_buf_sel, wr_reading, wr_flushed;
    logic [2:0]  wr_unit, cnt_sel;
    logic [15:0] wr_stride;

    int vectors = 0;
    int miscompares = 0;
    int lows;

    gpu_multi_raster_dispatch #(.NUM_RASTER(2), .CNT_W(32)) dut (
        .gpu_clk_i     (clk),
        .gpu_rst_ni    (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_addr_i    (cmd_addr),
        .cmd_data_i    (cmd_data),
        .ras_reg_wren_o(ras_reg_wren),
        .ras_reg_addr_o(ras_reg_addr),
        .ras_reg_data_o(ras_reg_data),
        .ras_start_o   (ras_start),
        .ras_busy_i    (ras_busy),
        .ras_clear_o   (ras_clear),
        .ras_buf_sel_o (ras_buf_sel),
        .wr_start_o    (wr_start),
        .wr_unit_o     (wr_unit),
        .wr_buf_sel_o  (wr_buf_sel),
        .wr_addr_o     (wr_addr),
        .wr_stride_o   (wr_stride),
        .wr_reading_i  (wr_reading),
        .wr_flushed_i  (wr_flushed),
        .cnt_sel_i     (cnt_sel),
        .cnt_data_o    (cnt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        ras_busy = '0; wr_reading = 1'b0; wr_flushed = 1'b1; cnt_sel = '0;
        #12;
        chk("rst_clear", 64'(ras_clear), 64'h3);
        chk("rst_bufsel", 64'(ras_buf_sel), 64'h0);
        chk("rst_start", 64'(ras_start), 64'h0);
        chk("rst_wrstart", 64'(wr_start), 64'h0);
        chk("rst_ready", 64'(cmd_ready), 64'h1);
        chk("rst_cnt", 64'(cnt_data), 64'h0);
        chk("rst_wraddr", 64'(wr_addr), 64'h0);
        rst_n = 1'b1;
        nxt();

        // Register broadcast under full mask, then mask 2'b10
        cmd(8'h10, 32'd5); #2;
        chk("wren_all", 64'(ras_reg_wren), 64'h3);
        chk("regdata5", 64'(ras_reg_data), 64'd5);
        chk("regaddr0", 64'(ras_reg_addr), 64'h0);
        nxt();
        cmd(8'h03, 32'd2); #2;
        chk("wren_mask_cmd", 64'(ras_reg_wren), 64'h0);
        nxt();
        cmd(8'h11, 32'd7); #2;
        chk("wren_masked", 64'(ras_reg_wren), 64'h2);
        chk("regdata7", 64'(ras_reg_data), 64'd7);
        chk("regaddr1", 64'(ras_reg_addr), 64'h1);
        nxt();
        cmd(8'h03, 32'd3); nxt();
        cmd(8'h01, 32'hDEAD_0000); nxt();
        cmd(8'h02, 32'h0001_2345); nxt();
        cmd_valid = 1'b0; #2;
        chk("wr_addr", 64'(wr_addr), 64'hDEAD_0000);
        chk("wr_stride", 64'(wr_stride), 64'h2345);
        nxt();

        // Three STARTs: unit0, unit1, third blocked by outstanding==2
        cmd(8'h00, 32'd0); #2;
        chk("start1_rdy", 64'(cmd_ready), 64'h1);
        chk("start1_u0", 64'(ras_start), 64'h1);
        nxt(); ras_busy = 2'b01; #2;
        chk("start2_u1", 64'(ras_start), 64'h2);
        nxt(); ras_busy = 2'b11; cnt_sel = 3'd5; #2;
        chk("start3_stall", 64'(cmd_ready), 64'h0);
        chk("start3_nostrobe", 64'(ras_start), 64'h0);
        nxt(); #2;
        chk("outst2", 64'(cnt_data), 64'd2);
        chk("clear_00", 64'(ras_clear), 64'h0);
        ras_busy = 2'b00; #1;
        chk("full_stall", 64'(cmd_ready), 64'h0);
        cmd(8'h00, 32'd2); #1;
        chk("wr1_rdy", 64'(cmd_ready), 64'h1);
        chk("wr1_start", 64'(wr_start), 64'h1);
        chk("wr1_unit", 64'(wr_unit), 64'h0);
        chk("wr1_bsel", 64'(wr_buf_sel), 64'h0);
        nxt(); wr_reading = 1'b1; #2;
        chk("bufsel_01", 64'(ras_buf_sel), 64'h1);
        chk("clear_01", 64'(ras_clear), 64'h1);
        cmd(8'h00, 32'd0); #1;
        chk("start3_u0", 64'(ras_start), 64'h1);
        nxt(); ras_busy = 2'b01; wr_reading = 1'b0;
        cmd(8'h00, 32'd2); #2;
        chk("wr2_unit", 64'(wr_unit), 64'h1);
        chk("wr2_start", 64'(wr_start), 64'h1);
        chk("wr2_bsel", 64'(wr_buf_sel), 64'h0);
        nxt(); #2;
        for (int i = 0; i < 3; i++) begin
            chk("wr3_busy_stall", 64'(cmd_ready), 64'h0);
            nxt(); #2;
        end
        ras_busy = 2'b00; #1;
        chk("wr3_start", 64'(wr_start), 64'h1);
        chk("wr3_unit", 64'(wr_unit), 64'h0);
        chk("wr3_bsel", 64'(wr_buf_sel), 64'h1);
        nxt(); cmd_valid = 1'b0; #2;
        chk("bufsel_10", 64'(ras_buf_sel), 64'h2);
        chk("clear_11", 64'(ras_clear), 64'h3);
        nxt(); #2;
        chk("outst0", 64'(cnt_data), 64'd0);

        // WRITE with nothing outstanding sets err
        cmd(8'h00, 32'd2); #2;
        chk("err_rdy", 64'(cmd_ready), 64'h1);
        chk("err_nowr", 64'(wr_start), 64'h0);
        nxt(); cmd_valid = 1'b0; cnt_sel = 3'd6;
        nxt(); #2;
        chk("status_err", 64'(cnt_data), 64'h49);
        cmd(8'h00, 32'd5); #2;
        chk("reset_rdy", 64'(cmd_ready), 64'h1);
        nxt(); cmd_valid = 1'b0;
        nxt(); #2;
        chk("status_clr", 64'(cnt_data), 64'h0);
        chk("reset_clear", 64'(ras_clear), 64'h3);
        chk("reset_keep_bsel", 64'(ras_buf_sel), 64'h2);

        // FENCE held off by wr_flushed for 20 cycles
        wr_flushed = 1'b0;
        cmd(8'h00, 32'd4);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (!cmd_ready) lows++;
            nxt();
        end
        chk("fence_lows", 64'(lows), 64'd20);
        wr_flushed = 1'b1; #2;
        chk("fence_rdy", 64'(cmd_ready), 64'h1);
        nxt(); cmd_valid = 1'b0; cnt_sel = 3'd4;
        nxt(); #2;
        chk("c4_stall", 64'(cnt_data), 64'd20);

        // RESET then idle
        cmd(8'h00, 32'd5); nxt();
        cmd_valid = 1'b0; cnt_sel = 3'd0;
        nxt(); #2;
        chk("c0_zero", 64'(cnt_data), 64'd0);
        cnt_sel = 3'd3;
        nxt(); #2;
        chk("c3_one", 64'(cnt_data), 64'd1);
        cnt_sel = 3'd0;
        repeat (100) nxt();
        #2;
        chk("c0_idle", 64'(cnt_data), 64'd101);
        cnt_sel = 3'd3;
        nxt(); #2;
        chk("c3_idle", 64'(cnt_data), 64'd102);
        cnt_sel = 3'd1;
        nxt(); #2;
        chk("c1_idle", 64'(cnt_data), 64'd0);

        // Asynchronous reset mid-command
        cmd(8'h00, 32'd0); nxt();
        ras_busy = 2'b01; #2;
        chk("pre_rst_start", 64'(ras_start), 64'h2);
        rst_n = 1'b0; #1;
        chk("async_start", 64'(ras_start), 64'h0);
        chk("async_clear", 64'(ras_clear), 64'h3);
        chk("async_wraddr", 64'(wr_addr), 64'h0);
        chk("async_bsel", 64'(ras_buf_sel), 64'h0);
        cmd_valid = 1'b0; ras_busy = 2'b00;
        nxt();
        rst_n = 1'b1;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
